uart_tx_module: RTL and testbench

//  UART transmitter: return path to the host for the UART_module receiver. Buffers bytes

---
 rtl/uart_tx_module.sv | 125 ++++++++++++
 tb/tb_uart_tx_module.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_module.sv
// uart_tx_module: FIFO-buffered UART transmitter, start + 8 data (LSB first) + optional parity + stop.
// One bit lasts 16 tick_16 pulses; all sequencing advances only on tick_16 cycles.
module uart_tx_module #(
    parameter int DEPTH      = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_16,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       Tx,
    output logic       busy,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     count_q, count_d;
    logic [3:0]      tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d, tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;
    logic            push, pop, last;

    always_comb begin
        tx_ready = count_q != (AW+1)'(DEPTH);
        push     = tx_valid && tx_ready;
        last     = tick_16 && tick_q == 4'd15;
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        pop      = 1'b0;
        if (tick_16 && state_q != IDLE) tick_d = tick_q + 4'd1;
        case (state_q)
            IDLE:   pop = tick_16 && count_q != '0;
            START:  if (last) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end
            DATA:   if (last) begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = PARITY_EN != 0 ? PARITY : STOP;
                            bit_d   = 3'd0;
                        end
                    end
            PARITY: if (last) begin
                        state_d = STOP;
                        bit_d   = 3'd0;
                    end
            STOP:   if (last) begin
                        if (bit_q == 3'(STOP_BITS - 1)) begin
                            state_d = IDLE;
                            bit_d   = 3'd0;
                            pop     = count_q != '0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
            default: state_d = IDLE;
        endcase
        // A pop always launches a fresh frame, whether from IDLE or straight out of STOP
        if (pop) begin
            state_d = START;
            tick_d  = 4'd0;
            shift_d = mem_q[rd_q];
            par_d   = (^mem_q[rd_q]) ^ (PARITY_ODD != 0);
        end
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        tx_d    = state_d == START  ? 1'b0 :
                  state_d == DATA   ? shift_d[0] :
                  state_d == PARITY ? par_d : 1'b1;
        busy_d  = state_d != IDLE || count_d != '0;
        ovf_d   = tx_valid && !tx_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= tx_data;
    end

    assign Tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_module.sv
// tb_uart_tx_module: directed checks of frame format, back-to-back frames, overflow, reset and tick rate.
// Three instances cover default, odd-parity and no-parity/two-stop configurations.
module tb_uart_tx_module;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_16 = 1'b0;
    logic [2:0] vld = '0;
    logic [7:0] dat [3];
    wire  [2:0] rdy, line, bsy, ovf;
    int         checks = 0;
    int         errors = 0;
    int         tick_per = 4;
    bit         tick_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_module u_def (
        .clk(clk), .rst(rst), .tick_16(tick_16), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .Tx(line[0]), .busy(bsy[0]), .overflow(ovf[0])
    );
    uart_tx_module #(.PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tick_16(tick_16), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .Tx(line[1]), .busy(bsy[1]), .overflow(ovf[1])
    );
    uart_tx_module #(.PARITY_EN(0), .STOP_BITS(2)) u_np (
        .clk(clk), .rst(rst), .tick_16(tick_16), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .Tx(line[2]), .busy(bsy[2]), .overflow(ovf[2])
    );

    initial begin
        int tc;
        tc = 0;
        forever begin
            @(negedge clk);
            if (!tick_en) begin
                tick_16 = 1'b0;
            end else begin
                tick_16 = (tc == 0);
                tc = (tc + 1 >= tick_per) ? 0 : tc + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int w, input logic [7:0] d);
        vld[w] = 1'b1;
        dat[w] = d;
        @(negedge clk);
        vld[w] = 1'b0;
    endtask

    // end_mode 1: line idle and not busy after the frame; 2: next start bit begins immediately
    task automatic frame(input int w, input logic [11:0] b, input int nb, input int p, input int end_mode);
        int n;
        n = 0;
        while (line[w] !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start", line[w], 0);
        for (int c = 0; c < nb * 16 * p; c++) begin
            if (c % (16 * p) == 8 * p) chk($sformatf("frame_bit%0d", c / (16 * p)), line[w], b[c / (16 * p)]);
            @(negedge clk);
        end
        if (end_mode == 1) begin
            chk("frame_end_busy", bsy[w], 0);
            chk("frame_end_line", line[w], 1);
        end else begin
            chk("frame_b2b_line", line[w], 0);
            chk("frame_b2b_busy", bsy[w], 1);
        end
    endtask

    initial begin
        int n, bad;
        dat[0] = '0;
        dat[1] = '0;
        dat[2] = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", line[0], 1);
        chk("rst_ready", rdy[0], 1);
        chk("rst_busy", bsy[0], 0);
        chk("rst_ovf", ovf[0], 0);
        rst = 1'b0;
        tick_en = 1'b1;

        push(0, 8'hA5);
        chk("t1_busy", bsy[0], 1);
        frame(0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 1);

        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        frame(0, {1'b1, 1'b1, 8'h01, 1'b0}, 11, 4, 2);
        frame(0, {1'b1, 1'b1, 8'h02, 1'b0}, 11, 4, 2);
        frame(0, {1'b1, 1'b0, 8'h03, 1'b0}, 11, 4, 1);
        chk("t2_ready", rdy[0], 1);

        tick_en = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            vld[0] = 1'b1;
            dat[0] = 8'h10 + 8'(k - 1);
            @(negedge clk);
            chk($sformatf("t3_ready%0d", k), rdy[0], k < 4);
            chk($sformatf("t3_ovf%0d", k), ovf[0], k >= 5);
        end
        vld[0] = 1'b0;
        @(negedge clk);
        chk("t3_ovf_end", ovf[0], 0);
        chk("t3_full", rdy[0], 0);
        tick_en = 1'b1;
        frame(0, {1'b1, 1'b1, 8'h10, 1'b0}, 11, 4, 2);
        frame(0, {1'b1, 1'b0, 8'h11, 1'b0}, 11, 4, 2);
        frame(0, {1'b1, 1'b0, 8'h12, 1'b0}, 11, 4, 2);
        frame(0, {1'b1, 1'b1, 8'h13, 1'b0}, 11, 4, 1);

        push(1, 8'h00);
        frame(1, {1'b1, 1'b1, 8'h00, 1'b0}, 11, 4, 1);
        push(2, 8'hFF);
        frame(2, {1'b1, 1'b1, 8'hFF, 1'b0}, 11, 4, 1);

        push(0, 8'h33);
        push(0, 8'h44);
        push(0, 8'h55);
        n = 0;
        while (line[0] !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_start", line[0], 0);
        repeat (288) @(negedge clk);
        chk("t5_bit3", line[0], 0);
        chk("t5_busy_pre", bsy[0], 1);
        rst = 1'b1;
        #1;
        chk("t5_tx", line[0], 1);
        chk("t5_busy", bsy[0], 0);
        chk("t5_ready", rdy[0], 1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (800) begin
            @(negedge clk);
            if (line[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
        end
        chk("t5_quiet", bad, 0);

        tick_per = 1;
        push(0, 8'h5A);
        frame(0, {1'b1, 1'b0, 8'h5A, 1'b0}, 11, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
